// File: rtl/cache_mem_responder.sv
// Memory-side responder for the set-associative cache: answers line fills after
// a programmable latency and commits eviction write-backs into a line store.
module cache_mem_responder #(
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 32,
  parameter int OFFSET_W  = 6,
  parameter int MEM_AW    = 10,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              i_evict,
  input  logic [ADDR_W-1:0] i_evict_addr,
  input  logic [LINE_W-1:0] i_evict_data,
  output logic [LINE_W-1:0] o_memory_line,
  output logic              o_memory_response,
  output logic              o_evict_ack,
  output logic              o_busy
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, WAITLOW} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [MEM_AW-1:0]  miss_line;
  logic [MEM_AW-1:0]  evict_line;
  logic [LINE_W-1:0]  evict_data;
  logic               pending;
  logic               wr_en;
  logic [LINE_W-1:0]  mem [2**MEM_AW];

  // Tag and offset bits never reach the store; lines 2^MEM_AW apart alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr[ADDR_W-1:OFFSET_W+MEM_AW], i_miss_addr[OFFSET_W-1:0],
                              i_evict_addr[ADDR_W-1:OFFSET_W+MEM_AW], i_evict_addr[OFFSET_W-1:0]};

  // Write commits on the same edge as the ack; reset forces IDLE so it aborts.
  assign wr_en = (state == WRITE) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (wr_en) mem[evict_line] <= evict_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt               <= '0;
      miss_line         <= '0;
      evict_line        <= '0;
      evict_data        <= '0;
      pending           <= 1'b0;
      o_memory_line     <= '0;
      o_memory_response <= 1'b0;
      o_evict_ack       <= 1'b0;
      o_busy            <= 1'b0;
    end else begin
      o_memory_response <= 1'b0;
      o_evict_ack       <= 1'b0;
      case (state)
        IDLE: begin
          o_memory_line <= '0;
          // Eviction wins a tie so a fill of the same line sees the new data.
          if (i_evict) begin
            evict_line <= i_evict_addr[OFFSET_W+MEM_AW-1:OFFSET_W];
            evict_data <= i_evict_data;
            cnt        <= CNT_W'(WRITE_LAT - 1);
            state      <= WRITE;
            o_busy     <= 1'b1;
            if (i_miss) begin
              miss_line <= i_miss_addr[OFFSET_W+MEM_AW-1:OFFSET_W];
              pending   <= 1'b1;
            end
          end else if (i_miss) begin
            miss_line <= i_miss_addr[OFFSET_W+MEM_AW-1:OFFSET_W];
            cnt       <= CNT_W'(READ_LAT - 1);
            state     <= READ;
            o_busy    <= 1'b1;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            o_evict_ack <= 1'b1;
            if (pending) begin
              pending <= 1'b0;
              cnt     <= CNT_W'(READ_LAT - 1);
              state   <= READ;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        READ: begin
          if (cnt == '0) begin
            o_memory_line <= mem[miss_line];
            state         <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          o_memory_response <= 1'b1;
          state             <= WAITLOW;
        end
        WAITLOW: begin
          // A level-held miss must drop before another request is accepted.
          o_memory_line <= '0;
          if (!i_miss) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed self-checking bench for cache_mem_responder: latency, ordering,
// level-held miss, aliasing and mid-operation reset.
module tb_cache_mem_responder;

  logic        clk;
  logic        rst;
  logic        i_miss;
  logic [31:0] i_miss_addr;
  logic        i_evict;
  logic [31:0] i_evict_addr;
  logic [31:0] i_evict_data;
  logic [31:0] o_memory_line;
  logic        o_memory_response;
  logic        o_evict_ack;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  cache_mem_responder dut (
    .clk               (clk),
    .rst               (rst),
    .i_miss            (i_miss),
    .i_miss_addr       (i_miss_addr),
    .i_evict           (i_evict),
    .i_evict_addr      (i_evict_addr),
    .i_evict_data      (i_evict_data),
    .o_memory_line     (o_memory_line),
    .o_memory_response (o_memory_response),
    .o_evict_ack       (o_evict_ack),
    .o_busy            (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle c is observed at the falling edge after the c-th rising edge from the
  // call; the evict handshake is dropped on ack and the miss optionally on response.
  task automatic run_cycles(input int n, input bit drop_miss, output int ack_at,
                            output int resp_at, output int resp_cnt, output logic [31:0] line);
    ack_at = -1; resp_at = -1; resp_cnt = 0; line = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (o_evict_ack) begin
        if (ack_at < 0) ack_at = c;
        i_evict = 1'b0;
      end
      if (o_memory_response) begin
        resp_cnt++;
        if (resp_at < 0) begin
          resp_at = c;
          line    = o_memory_line;
        end
        if (drop_miss) i_miss = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int a, r, n;
    logic [31:0] l;
    @(negedge clk);
    rst = 1'b0; i_miss = 1'b1; i_miss_addr = 32'h0000_0100;
    repeat (2) @(negedge clk);
    total++; if (o_memory_response !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp: got %b want 0", o_memory_response); end
    total++; if (o_evict_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", o_evict_ack); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_memory_line !== 32'h0) begin bad++; $display("[TB] FAIL reset_line: got %h want 0", o_memory_line); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_accept_busy: got %b want 1", o_busy); end
    run_cycles(10, 1'b1, a, r, n, l);
    total++; if (r !== 5) begin bad++; $display("[TB] FAIL reset_accept_latency: got %0d want 5", r); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int a, r, n;
    logic [31:0] l;
    i_evict = 1'b1; i_evict_addr = 32'h0000_0040; i_evict_data = 32'hDEAD_BEEF;
    run_cycles(6, 1'b0, a, r, n, l);
    total++; if (a !== 3) begin bad++; $display("[TB] FAIL wr_ack_latency: got %0d want 3", a); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL wr_idle_busy: got %b want 0", o_busy); end
    i_miss = 1'b1; i_miss_addr = 32'h0000_0044;
    run_cycles(12, 1'b1, a, r, n, l);
    total++; if (r !== 6) begin bad++; $display("[TB] FAIL rd_latency: got %0d want 6", r); end
    total++; if (l !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL rd_data: got %h want deadbeef", l); end
    total++; if (n !== 1) begin bad++; $display("[TB] FAIL rd_pulse_count: got %0d want 1", n); end
    total++; if (o_memory_line !== 32'h0) begin bad++; $display("[TB] FAIL rd_line_cleared: got %h want 0", o_memory_line); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL rd_idle_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_evict_miss();
    int a, r, n;
    logic [31:0] l;
    i_evict = 1'b1; i_evict_addr = 32'h0000_0080; i_evict_data = 32'h1234_5678;
    i_miss  = 1'b1; i_miss_addr  = 32'h0000_0080;
    run_cycles(14, 1'b1, a, r, n, l);
    total++; if (a !== 3) begin bad++; $display("[TB] FAIL em_ack_latency: got %0d want 3", a); end
    total++; if (r !== 8) begin bad++; $display("[TB] FAIL em_resp_latency: got %0d want 8", r); end
    total++; if (l !== 32'h1234_5678) begin bad++; $display("[TB] FAIL em_data: got %h want 12345678", l); end
    total++; if (n !== 1) begin bad++; $display("[TB] FAIL em_pulse_count: got %0d want 1", n); end
  endtask

  task automatic test_level_held();
    int a, r, n;
    logic [31:0] l;
    i_miss = 1'b1; i_miss_addr = 32'h0000_0040;
    run_cycles(16, 1'b0, a, r, n, l);
    total++; if (r !== 6) begin bad++; $display("[TB] FAIL held_latency: got %0d want 6", r); end
    total++; if (l !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL held_data: got %h want deadbeef", l); end
    total++; if (n !== 1) begin bad++; $display("[TB] FAIL held_pulse_count: got %0d want 1", n); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL held_busy: got %b want 1", o_busy); end
    i_miss = 1'b0;
    @(negedge clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL held_release_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_alias();
    int a, r, n;
    logic [31:0] l;
    i_evict = 1'b1; i_evict_addr = 32'h0000_00C0; i_evict_data = 32'hA5A5_A5A5;
    run_cycles(5, 1'b0, a, r, n, l);
    total++; if (a !== 3) begin bad++; $display("[TB] FAIL alias_ack_latency: got %0d want 3", a); end
    i_miss = 1'b1; i_miss_addr = 32'h0001_00C0;
    run_cycles(10, 1'b1, a, r, n, l);
    total++; if (r !== 6) begin bad++; $display("[TB] FAIL alias_latency: got %0d want 6", r); end
    total++; if (l !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL alias_data: got %h want a5a5a5a5", l); end
  endtask

  task automatic test_mid_reset();
    int a, r, n;
    logic [31:0] l;
    i_miss = 1'b1; i_miss_addr = 32'h0000_0080;
    repeat (3) @(negedge clk);
    rst = 1'b0; i_miss = 1'b0;
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL midrd_busy: got %b want 0", o_busy); end
    run_cycles(2, 1'b0, a, r, n, l);
    rst = 1'b1;
    run_cycles(6, 1'b0, a, r, n, l);
    total++; if (n !== 0) begin bad++; $display("[TB] FAIL midrd_no_resp: got %0d want 0", n); end
    i_evict = 1'b1; i_evict_addr = 32'h0000_0080; i_evict_data = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    rst = 1'b0; i_evict = 1'b0;
    #1;
    total++; if (o_evict_ack !== 1'b0) begin bad++; $display("[TB] FAIL midwr_ack: got %b want 0", o_evict_ack); end
    run_cycles(2, 1'b0, a, r, n, l);
    rst = 1'b1;
    total++; if (a !== -1) begin bad++; $display("[TB] FAIL midwr_no_ack: got %0d want -1", a); end
    i_miss = 1'b1; i_miss_addr = 32'h0000_0080;
    run_cycles(10, 1'b1, a, r, n, l);
    total++; if (r !== 6) begin bad++; $display("[TB] FAIL midrst_reissue_latency: got %0d want 6", r); end
    total++; if (l !== 32'h1234_5678) begin bad++; $display("[TB] FAIL midrst_store_data: got %h want 12345678", l); end
  endtask

  initial begin
    rst = 1'b1; i_miss = 1'b0; i_miss_addr = '0;
    i_evict = 1'b0; i_evict_addr = '0; i_evict_data = '0;
    #1 rst = 1'b0;
    #20 rst = 1'b1;
    test_reset();
    test_write_read();
    test_evict_miss();
    test_level_held();
    test_alias();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
